// File: rtl/vga_seq_pkg.sv
// Shared types and geometry constants for the VGA tile-reveal sequencer.
package vga_seq_pkg;

  typedef enum logic [1:0] {END, GAME, REVEAL, HOLD} seq_state_e;

  localparam int TILE_COUNT_DEFAULT = 12;
  localparam int TILE_PX            = 160;
  localparam int GRID_COLS          = 4;
  localparam int REV_W              = $clog2(TILE_COUNT_DEFAULT + 1);

endpackage

// File: rtl/frame_tick_counter.sv
// Modulo-N frame counter: steps on advance, synchronous clear wins, flags the last count.
module frame_tick_counter #(
  parameter int N = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic advance,
  input  logic clear,
  output logic terminal
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [CW-1:0] count;

  assign terminal = (count == CW'(N - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (advance) begin
      count <= terminal ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/vga_reveal_sequencer.sv
// Chooses game board vs end screen and reveals tiles toward min(score, TILE_COUNT),
// committing every visible change on a frame boundary so the display never tears.
module vga_reveal_sequencer
  import vga_seq_pkg::*;
#(
  parameter int TILE_COUNT      = TILE_COUNT_DEFAULT,
  parameter int FRAMES_PER_STEP = 8,
  parameter int HOLD_FRAMES     = 120,
  parameter int SCORE_WIDTH     = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   screen_end,
  input  logic                   ingame,
  input  logic [SCORE_WIDTH-1:0] score,
  output logic                   show_game,
  output logic [TILE_COUNT-1:0]  tile_mask,
  output logic                   busy,
  output logic                   reveal_done
);

  localparam int RV_W = $clog2(TILE_COUNT + 1);

  seq_state_e             state, state_n;
  logic [RV_W-1:0]        revealed, revealed_n, target, step;
  logic                   ingame_q;
  logic [SCORE_WIDTH-1:0] score_q;
  logic                   done_n;
  logic                   frame_clr, frame_adv, frame_term;
  logic                   hold_clr, hold_adv, hold_term;

  function automatic logic [TILE_COUNT-1:0] decode_mask(input logic [RV_W-1:0] n);
    logic [TILE_COUNT-1:0] m;
    for (int i = 0; i < TILE_COUNT; i++) m[i] = (i < int'(n));
    return m;
  endfunction

  // Full-width compare so large scores clamp rather than alias after truncation.
  assign target = (score_q >= SCORE_WIDTH'(TILE_COUNT)) ? RV_W'(TILE_COUNT)
                                                         : score_q[RV_W-1:0];
  assign step   = revealed + RV_W'(1);

  frame_tick_counter #(.N(FRAMES_PER_STEP)) u_frame_cnt (
    .clk(clk), .reset(reset), .advance(frame_adv), .clear(frame_clr), .terminal(frame_term)
  );

  frame_tick_counter #(.N(HOLD_FRAMES)) u_hold_cnt (
    .clk(clk), .reset(reset), .advance(hold_adv), .clear(hold_clr), .terminal(hold_term)
  );

  always_comb begin
    state_n    = state;
    revealed_n = revealed;
    done_n     = 1'b0;
    frame_clr  = 1'b0;
    frame_adv  = 1'b0;
    hold_clr   = 1'b0;
    hold_adv   = 1'b0;
    if (screen_end) begin
      unique case (state)
        END: begin
          revealed_n = '0;
          if (ingame_q) state_n = GAME;
        end
        GAME: begin
          if (!ingame_q) begin
            state_n  = HOLD;
            hold_clr = 1'b1;
          end else if (target > revealed) begin
            state_n   = REVEAL;
            frame_clr = 1'b1;
          end else if (target < revealed) begin
            revealed_n = target;
          end
        end
        REVEAL: begin
          if (!ingame_q) begin
            state_n  = HOLD;
            hold_clr = 1'b1;
          end else if (target <= revealed) begin
            revealed_n = target;
            state_n    = GAME;
          end else if (frame_term) begin
            revealed_n = step;
            frame_clr  = 1'b1;
            if (step == target) begin
              state_n = GAME;
              done_n  = 1'b1;
            end
          end else begin
            frame_adv = 1'b1;
          end
        end
        HOLD: begin
          if (ingame_q) begin
            state_n    = GAME;
            revealed_n = '0;
          end else if (hold_term) begin
            state_n    = END;
            revealed_n = '0;
          end else begin
            hold_adv = 1'b1;
          end
        end
        default: state_n = END;
      endcase
    end
  end

  // Outputs are registered from next-state values, so they move one edge after screen_end.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= END;
      revealed    <= '0;
      ingame_q    <= 1'b0;
      score_q     <= '0;
      show_game   <= 1'b0;
      tile_mask   <= '0;
      busy        <= 1'b0;
      reveal_done <= 1'b0;
    end else begin
      ingame_q    <= ingame;
      score_q     <= score;
      state       <= state_n;
      revealed    <= revealed_n;
      show_game   <= (state_n != END);
      busy        <= (state_n == REVEAL);
      tile_mask   <= decode_mask(revealed_n);
      reveal_done <= done_n;
    end
  end

endmodule

// File: tb/tb_vga_reveal_sequencer.sv
// Scoreboard bench: each frame pushes the expected post-boundary outputs; a monitor
// pops on every boundary and also requires outputs to stay put between boundaries.
module tb_vga_reveal_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        screen_end = 1'b0;
  logic        ingame = 1'b0;
  logic [31:0] score = '0;
  logic        show_game;
  logic [11:0] tile_mask;
  logic        busy;
  logic        reveal_done;

  int n_chk = 0;
  int n_pass = 0;

  logic [14:0] exp_q[$];
  logic [14:0] snap = '0;
  logic [14:0] got, e;
  bit          se_seen = 1'b0;

  vga_reveal_sequencer #(
    .TILE_COUNT(12), .FRAMES_PER_STEP(2), .HOLD_FRAMES(3), .SCORE_WIDTH(32)
  ) dut (
    .clk(clk), .reset(reset), .screen_end(screen_end), .ingame(ingame), .score(score),
    .show_game(show_game), .tile_mask(tile_mask), .busy(busy), .reveal_done(reveal_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
  endtask

  always @(posedge clk) se_seen <= screen_end;

  // Monitor: vector is {show_game, tile_mask, busy, reveal_done}
  always @(negedge clk) begin
    got = {show_game, tile_mask, busy, reveal_done};
    if (!reset) begin
      snap = '0;
    end else if (se_seen) begin
      if (exp_q.size() == 0) begin
        check("unexpected_boundary", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("frame_outputs", {17'd0, got}, {17'd0, e});
      end
      snap = {got[14:1], 1'b0};
    end else begin
      check("stable_between_frames", {17'd0, got}, {17'd0, snap});
    end
  end

  // One 20-clock frame: inputs applied at frame start, boundary pulse at the end.
  task automatic frame(input logic ig, input logic [31:0] sc,
                       input logic sh, input logic [11:0] mk, input logic bz, input logic dn);
    ingame = ig;
    score  = sc;
    repeat (19) @(negedge clk);
    exp_q.push_back({sh, mk, bz, dn});
    screen_end = 1'b1;
    @(negedge clk);
    screen_end = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b0;
    #1 check("reset_initial", {17'd0, show_game, tile_mask, busy, reveal_done}, 32'd0);
    repeat (3) @(negedge clk);
    check("reset_held", {17'd0, show_game, tile_mask, busy, reveal_done}, 32'd0);
    reset = 1'b1;

    // Start a game: board shows one clock after the boundary
    frame(1, 0, 1, 12'h000, 0, 0);

    // Reveal three tiles, one per two frames
    frame(1, 3, 1, 12'h000, 1, 0);
    frame(1, 3, 1, 12'h000, 1, 0);
    frame(1, 3, 1, 12'h001, 1, 0);
    frame(1, 3, 1, 12'h001, 1, 0);
    frame(1, 3, 1, 12'h003, 1, 0);
    frame(1, 3, 1, 12'h003, 1, 0);
    frame(1, 3, 1, 12'h007, 0, 1);
    frame(1, 3, 1, 12'h007, 0, 0);

    // Oversized score clamps to 12 tiles
    frame(1, 40, 1, 12'h007, 1, 0);
    for (int k = 4; k <= 12; k++) begin
      frame(1, 40, 1, 12'((1 << (k - 1)) - 1), 1, 0);
      frame(1, 40, 1, 12'((1 << k) - 1), (k != 12), (k == 12));
    end
    frame(1, 40, 1, 12'hFFF, 0, 0);
    frame(1, 5,  1, 12'h01F, 0, 0);

    // Max score starts a reveal; a drop below revealed snaps back with no pulse
    frame(1, 32'hFFFF_FFFF, 1, 12'h01F, 1, 0);
    frame(1, 4,             1, 12'h00F, 0, 0);
    frame(1, 16,            1, 12'h00F, 1, 0);

    // Game ends mid-reveal: board frozen for the hold, then end screen
    frame(0, 16, 1, 12'h00F, 0, 0);
    frame(0, 16, 1, 12'h00F, 0, 0);
    frame(0, 16, 1, 12'h00F, 0, 0);
    frame(0, 16, 0, 12'h000, 0, 0);
    frame(0, 16, 0, 12'h000, 0, 0);

    // New game, then ingame re-rises during the hold
    frame(1, 2, 1, 12'h000, 0, 0);
    frame(1, 2, 1, 12'h000, 1, 0);
    frame(1, 2, 1, 12'h000, 1, 0);
    frame(1, 2, 1, 12'h001, 1, 0);
    frame(0, 2, 1, 12'h001, 0, 0);
    frame(0, 2, 1, 12'h001, 0, 0);
    frame(1, 2, 1, 12'h000, 0, 0);
    frame(1, 2, 1, 12'h000, 1, 0);
    frame(1, 2, 1, 12'h000, 1, 0);
    frame(1, 2, 1, 12'h001, 1, 0);
    frame(1, 2, 1, 12'h001, 1, 0);
    frame(1, 2, 1, 12'h003, 0, 1);

    // Glitches between boundaries are invisible if restored before the next one
    ingame = 1'b1; score = 2;
    repeat (3) @(negedge clk);
    ingame = 1'b0; score = 40;
    repeat (5) @(negedge clk);
    ingame = 1'b1; score = 2;
    repeat (11) @(negedge clk);
    exp_q.push_back({1'b1, 12'h003, 1'b0, 1'b0});
    screen_end = 1'b1;
    @(negedge clk);
    screen_end = 1'b0;

    // Reset mid-reveal returns to idle immediately, no pulse
    frame(1, 5, 1, 12'h003, 1, 0);
    repeat (7) @(negedge clk);
    reset = 1'b0;
    #1 check("reset_mid_reveal", {17'd0, show_game, tile_mask, busy, reveal_done}, 32'd0);
    repeat (3) @(negedge clk);
    check("reset_mid_held", {17'd0, show_game, tile_mask, busy, reveal_done}, 32'd0);
    reset = 1'b1;
    frame(1, 5, 1, 12'h000, 0, 0);
    frame(1, 5, 1, 12'h000, 1, 0);

    repeat (2) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got no completion expected finish before 1ms");
    $fatal(1);
  end

endmodule
